// File: rtl/ofdm_frame_ctrl.sv
// OFDM frame sequencer: buffers mapped points and emits NFFT ordered slots with nulls and pilots.
// Optional macro PILOT_PRBS_EN: pilot polarity from a 7-bit LFSR (x^7+x^4+1) instead of alternating.
module ofdm_frame_ctrl #(
    parameter int                 NFFT          = 16,
    parameter int                 GUARD         = 2,
    parameter int                 PILOT_SPACING = 4,
    parameter int                 PILOT_OFFSET  = 2,
    parameter logic signed [15:0] PILOT_AMP     = 16'sd1,
    parameter int                 FIFO_DEPTH    = 4,
    localparam int                IDXW          = $clog2(NFFT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          num_sym,
    output logic                busy,
    output logic                done,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic signed [15:0]  sym_x,
    input  logic signed [15:0]  sym_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [15:0]  out_re,
    output logic signed [15:0]  out_im,
    output logic [IDXW-1:0]     out_idx,
    output logic                out_eof,
    output logic                out_last
);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    function automatic logic f_is_null(input logic [IDXW-1:0] k);
        int ki = int'(k);
        return (ki == 0) || ((ki >= NFFT / 2 - GUARD) && (ki < NFFT / 2 + GUARD));
    endfunction

    function automatic logic f_is_pilot(input logic [IDXW-1:0] k);
        int ki = int'(k);
        return (ki % PILOT_SPACING) == PILOT_OFFSET;
    endfunction

`ifdef PILOT_PRBS_EN
    function automatic logic [6:0] f_lfsr_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[3]};
    endfunction
    logic [6:0]        r_lfsr;
`else
    logic              r_pol;
`endif

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_mem_x [FIFO_DEPTH];
    logic [15:0]       r_mem_y [FIFO_DEPTH];
    logic [PTRW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic [IDXW-1:0]   r_k;
    logic [7:0]        r_sym, r_num_sym;
    logic              r_busy, r_done, r_out_valid, r_out_eof, r_out_last;
    logic signed [15:0] r_out_re, r_out_im;
    logic [IDXW-1:0]   r_out_idx;

    logic              w_push, w_pop, w_fifo_empty, w_xfer, w_start_ok, w_frame_end;
    logic              w_k_null, w_k_pilot, w_k_data, w_advance, w_load, w_pilot_neg;
    logic              w_slot_eof, w_slot_last;
    logic signed [15:0] w_slot_re, w_slot_im;

    assign sym_ready    = (r_count < CNTW'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == {CNTW{1'b0}});
    assign w_push       = sym_valid && sym_ready;
    assign w_xfer       = r_out_valid && out_ready;

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_eof   = r_out_eof;
    assign out_last  = r_out_last;

    // Point storage; contents need no reset since pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= sym_x;
            r_mem_y[r_wr_ptr] <= sym_y;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTRW{1'b0}};
            r_rd_ptr <= {PTRW{1'b0}};
            r_count  <= {CNTW{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: start is ignored while running or with a zero symbol count
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = (r_state == S_IDLE) && start && (num_sym != 8'd0);
        w_frame_end = (r_state == S_RUN) && w_xfer && r_out_last;
        case (r_state)
            S_IDLE:  if (w_start_ok)  w_state_nxt = S_RUN;  else w_state_nxt = S_IDLE;
            S_RUN:   if (w_frame_end) w_state_nxt = S_IDLE; else w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef PILOT_PRBS_EN
    assign w_pilot_neg = r_lfsr[6];
`else
    assign w_pilot_neg = r_pol;
`endif

    // FSM outputs: next-slot classification and load decision; only data slots can stall
    always_comb begin
        w_k_null   = f_is_null(r_k);
        w_k_pilot  = !w_k_null && f_is_pilot(r_k);
        w_k_data   = !w_k_null && !w_k_pilot;
        w_advance  = (r_state == S_RUN) && (!r_out_valid || out_ready) && !w_frame_end;
        w_load     = w_advance && !(w_k_data && w_fifo_empty);
        w_pop      = w_load && w_k_data;
        w_slot_eof = (r_k == IDXW'(NFFT - 1));
        w_slot_last = w_slot_eof && (r_sym == (r_num_sym - 8'd1));
        w_slot_re  = 16'sd0;
        w_slot_im  = 16'sd0;
        if (w_k_null) begin
            w_slot_re = 16'sd0;
            w_slot_im = 16'sd0;
        end else if (w_k_pilot) begin
            w_slot_re = w_pilot_neg ? -PILOT_AMP : PILOT_AMP;
            w_slot_im = 16'sd0;
        end else begin
            w_slot_re = r_mem_x[r_rd_ptr];
            w_slot_im = r_mem_y[r_rd_ptr];
        end
    end

    // Output slot register, frame bookkeeping and pilot polarity
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= 16'sd0;
            r_out_im    <= 16'sd0;
            r_out_idx   <= {IDXW{1'b0}};
            r_out_eof   <= 1'b0;
            r_out_last  <= 1'b0;
            r_k         <= {IDXW{1'b0}};
            r_sym       <= 8'd0;
            r_num_sym   <= 8'd0;
`ifdef PILOT_PRBS_EN
            r_lfsr      <= 7'h7F;
`else
            r_pol       <= 1'b0;
`endif
        end else if (w_start_ok) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_re    <= 16'sd0;
            r_out_im    <= 16'sd0;
            r_out_idx   <= {IDXW{1'b0}};
            r_out_eof   <= 1'b0;
            r_out_last  <= 1'b0;
            r_k         <= IDXW'(1);
            r_sym       <= 8'd0;
            r_num_sym   <= num_sym;
`ifdef PILOT_PRBS_EN
            r_lfsr      <= 7'h7F;
`else
            r_pol       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_frame_end) begin
                r_out_valid <= 1'b0;
                r_out_eof   <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_re    <= w_slot_re;
                r_out_im    <= w_slot_im;
                r_out_idx   <= r_k;
                r_out_eof   <= w_slot_eof;
                r_out_last  <= w_slot_last;
                r_k         <= r_k + IDXW'(1);
                if (w_slot_eof) r_sym <= r_sym + 8'd1;
            end else if (w_advance) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && r_out_eof) begin
`ifdef PILOT_PRBS_EN
                r_lfsr <= f_lfsr_next(r_lfsr);
`else
                r_pol  <= ~r_pol;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// Directed bench for ofdm_frame_ctrl (default parameters, PILOT_PRBS_EN undefined).
module tb_ofdm_frame_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, sym_valid, out_ready;
    logic [7:0]  num_sym;
    logic [15:0] sym_x, sym_y;
    logic        busy, done, sym_ready, out_valid, out_eof, out_last;
    logic [15:0] out_re, out_im;
    logic [3:0]  out_idx;

    always #5 clk = ~clk;

    ofdm_frame_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_sym(num_sym),
        .busy(busy), .done(done), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_x(sym_x), .sym_y(sym_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_eof(out_eof), .out_last(out_last)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [31:0] feed_q[$];
    logic [31:0] exp_q[$];
    bit  feed_en = 1'b0;
    int  feed_gap = 0;
    int  gap_cnt = 0;
    int  m_k, m_sym, m_nsym, xfers, done_cnt;
    bit  m_pol, ready_low;
    int  xfer_cyc[16];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // 0 = null, 1 = pilot, 2 = data, tabulated by hand for NFFT=16, GUARD=2, pilots at k%4==2
    function automatic int slot_class(input int k);
        case (k)
            0, 6, 7, 8, 9: return 0;
            2, 10, 14:     return 1;
            default:       return 2;
        endcase
    endfunction

    task automatic mon_step();
        logic [31:0] pt;
        if (!reset && out_valid === 1'b1 && out_ready) begin
            xfers++;
            if (m_sym == 0) xfer_cyc[m_k] = cyc;
            chk_val("idx", 32'(out_idx), 32'(m_k));
            case (slot_class(m_k))
                0: begin
                    chk_val("null_re", 32'(out_re), 32'd0);
                    chk_val("null_im", 32'(out_im), 32'd0);
                end
                1: begin
                    chk_val("pilot_re", 32'(out_re), m_pol ? 32'h0000FFFF : 32'h00000001);
                    chk_val("pilot_im", 32'(out_im), 32'd0);
                end
                default: begin
                    if (exp_q.size() == 0) begin
                        chk_val("data_avail", 32'd0, 32'd1);
                    end else begin
                        pt = exp_q.pop_front();
                        chk_val("data_re", 32'(out_re), 32'(pt[31:16]));
                        chk_val("data_im", 32'(out_im), 32'(pt[15:0]));
                    end
                end
            endcase
            chk_val("eof", 32'(out_eof), 32'(m_k == 15));
            chk_val("last", 32'(out_last), 32'((m_k == 15) && (m_sym == m_nsym - 1)));
            m_k++;
            if (m_k == 16) begin
                m_k = 0;
                m_sym++;
                m_pol = !m_pol;
            end
        end
    endtask

    task automatic tick();
        mon_step();
        if (sym_valid && sym_ready === 1'b1 && !reset) begin
            exp_q.push_back(feed_q.pop_front());
            gap_cnt = feed_gap;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        if (sym_ready === 1'b0) ready_low = 1'b1;
        @(negedge clk);
        cyc++;
        if (done === 1'b1) done_cnt++;
        sym_valid = feed_en && (feed_q.size() > 0) && (gap_cnt == 0);
        if (sym_valid) begin
            sym_x = feed_q[0][31:16];
            sym_y = feed_q[0][15:0];
        end
    endtask

    task automatic add_pts(input int n, input int base);
        for (int i = 0; i < n; i++)
            feed_q.push_back({16'(base + i), 16'(-(3 * i) - base)});
    endtask

    task automatic start_frame(input int n);
        m_k = 0; m_sym = 0; m_pol = 1'b0; m_nsym = n; xfers = 0; done_cnt = 0;
        start = 1'b1;
        num_sym = 8'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk_val(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_idx(input int k, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid === 1'b1 && out_idx == 4'(k)) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk_val(tag, 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_pts [8];
        logic [15:0] h_re, h_im;
        logic [3:0]  h_idx;
        t1_pts = '{32'h0001_0001, 32'hFFFF_0001, 32'h0001_FFFF, 32'hFFFF_FFFF,
                   32'h0002_FFFE, 32'hFFFD_0003, 32'h0004_0005, 32'hFFFA_FFF9};
        reset = 1'b1; start = 1'b0; num_sym = 8'd0; sym_valid = 1'b0;
        sym_x = 16'd0; sym_y = 16'd0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);
        chk_val("rst_valid", 32'(out_valid), 32'd0);
        chk_val("rst_ready", 32'(sym_ready), 32'd1);
        chk_val("rst_idx", 32'(out_idx), 32'd0);
        chk_val("rst_re", 32'(out_re), 32'd0);
        chk_val("rst_flags", 32'({out_eof, out_last}), 32'd0);

        // Single symbol at full rate with prebuffered data
        for (int i = 0; i < 8; i++) feed_q.push_back(t1_pts[i]);
        feed_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk_val("t1_full", 32'(sym_ready), 32'd0);
        start_frame(1);
        for (int i = 0; i < 16; i++) begin
            chk_val("t1_rate", 32'(out_valid), 32'd1);
            tick();
        end
        chk_val("t1_done", 32'(done), 32'd1);
        chk_val("t1_busy", 32'(busy), 32'd0);
        chk_val("t1_valid_end", 32'(out_valid), 32'd0);
        chk_val("t1_xfers", 32'(xfers), 32'd16);
        chk_val("t1_consumed", 32'(exp_q.size()), 32'd0);
        tick();
        chk_val("t1_done_pulse", 32'(done), 32'd0);

        // Two symbols: pilot polarity flips, out_last only at the end
        add_pts(16, 100);
        start_frame(2);
        wait_done(200, "t2_done_seen");
        chk_val("t2_xfers", 32'(xfers), 32'd32);
        tick(); tick();

        // Starved FIFO: one point every 10 cycles
        chk_val("t3_fifo_empty", 32'(exp_q.size()), 32'd0);
        feed_gap = 9; gap_cnt = 9; ready_low = 1'b0;
        add_pts(8, 300);
        start_frame(1);
        chk_val("t3_idx0_valid", 32'(out_valid), 32'd1);
        tick();
        chk_val("t3_stall_valid", 32'(out_valid), 32'd0);
        wait_done(400, "t3_done_seen");
        chk_val("t3_xfers", 32'(xfers), 32'd16);
        chk_val("t3_burst_6_10", 32'(xfer_cyc[10] - xfer_cyc[6]), 32'd4);
        chk_val("t3_ready_low", 32'(ready_low), 32'd0);
        feed_gap = 0; gap_cnt = 0;

        // Output backpressure at idx 3
        add_pts(8, 500);
        start_frame(1);
        wait_idx(3, "t4_reach_idx3");
        out_ready = 1'b0;
        h_re = out_re; h_im = out_im; h_idx = out_idx;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_val("t4_hold_valid", 32'(out_valid), 32'd1);
            chk_val("t4_hold_idx", 32'(out_idx), 32'(h_idx));
            chk_val("t4_hold_re", 32'(out_re), 32'(h_re));
            chk_val("t4_hold_im", 32'(out_im), 32'(h_im));
        end
        chk_val("t4_full", 32'(sym_ready), 32'd0);
        out_ready = 1'b1;
        wait_done(200, "t4_done_seen");
        chk_val("t4_xfers", 32'(xfers), 32'd16);
        chk_val("t4_no_loss", 32'(exp_q.size() + feed_q.size()), 32'd0);

        // Ignored starts: zero symbol count, and start while busy
        start = 1'b1; num_sym = 8'd0; done_cnt = 0;
        tick();
        start = 1'b0;
        chk_val("t5_zero_busy", 32'(busy), 32'd0);
        chk_val("t5_zero_valid", 32'(out_valid), 32'd0);
        tick(); tick();
        chk_val("t5_zero_done", 32'(done_cnt), 32'd0);
        add_pts(8, 700);
        start_frame(1);
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1; num_sym = 8'd3;
        tick();
        start = 1'b0;
        wait_done(200, "t5_done_seen");
        chk_val("t5_xfers", 32'(xfers), 32'd16);
        tick(); tick(); tick();
        chk_val("t5_one_done", 32'(done_cnt), 32'd1);
        chk_val("t5_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of symbol 0, then a clean two-symbol frame
        add_pts(8, 900);
        start_frame(1);
        wait_idx(5, "t6_reach_idx5");
        feed_en = 1'b0; sym_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_val("t6_valid", 32'(out_valid), 32'd0);
        chk_val("t6_busy", 32'(busy), 32'd0);
        chk_val("t6_ready", 32'(sym_ready), 32'd1);
        chk_val("t6_idx", 32'(out_idx), 32'd0);
        exp_q.delete();
        feed_q.delete();
        feed_en = 1'b1;
        add_pts(16, 1100);
        start_frame(2);
        chk_val("t6_restart_idx", 32'(out_idx), 32'd0);
        wait_done(200, "t6_done_seen");
        chk_val("t6_xfers", 32'(xfers), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
